param_updown_counter: RTL and testbench

Parametrised successor to the team's fixed 8-bit enable-gated up counter. It adds:
- configurable width and modulus
- up/down direction
- synchronous parallel load
- built-in prescaler, so the counter can advance slower than clk
- terminal-count and wrap-event outputs for cascading stages or driving display/LED logic on the board

It sits between the board clock domain and downstream display or sequencing logic.

---
 rtl/param_updown_counter.sv | 211 +++++++++++++++++++++
 tb/tb_param_updown_counter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/param_updown_counter.sv
// -----------------------------------------------------------------------------
// param_updown_counter
//
// Parametrised up/down modulo counter with a built-in prescaler, synchronous
// parallel load, terminal-count and wrap-event outputs. The count range is
// 0..MAX_VAL. One count step happens every PRESCALE enabled clock cycles.
//
// Parameters:
//   WIDTH    - counter bit width (1..32)
//   MAX_VAL  - highest count value, MAX_VAL <= 2^WIDTH-1
//   PRESCALE - enabled clk cycles per count step (1..65535)
//
// Ports:
//   clk      in   system clock, rising-edge
//   rst      in   synchronous reset, active-high
//   En       in   count enable; low freezes count and prescaler
//   up_dn    in   direction, 1 = up, 0 = down
//   load     in   synchronous parallel load strobe (ignores En)
//   load_val in   value to load, clamped to MAX_VAL
//   cnt      out  current count (registered)
//   step     out  registered pulse, high in the cycle the new count appears
//   tc       out  terminal count, combinational from cnt and up_dn
//   wrap     out  registered pulse, high in the cycle after a wrap-around step
// -----------------------------------------------------------------------------
module param_updown_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = 255,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             En,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             step,
  output logic             tc,
  output logic             wrap
);

  // Prescaler needs at least one bit even when every cycle is a tick.
  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [WIDTH-1:0] MAX_C   = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ZERO_C  = {WIDTH{1'b0}};
  // One bit wider so the clamp compare stays meaningful when MAX_VAL is all ones.
  localparam logic [WIDTH:0]   MAX_X   = {1'b0, MAX_C};
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0]  PS_ZERO = {PS_W{1'b0}};

  // Next value when stepping up: {wrap, count}
  function automatic logic [WIDTH:0] count_up(input logic [WIDTH-1:0] c);
    logic [WIDTH:0] r;
    if (c == MAX_C) begin
      r = {1'b1, ZERO_C};
    end else begin
      r = {1'b0, c + WIDTH'(1)};
    end
    return r;
  endfunction

  // Next value when stepping down: {wrap, count}
  function automatic logic [WIDTH:0] count_down(input logic [WIDTH-1:0] c);
    logic [WIDTH:0] r;
    if (c == ZERO_C) begin
      r = {1'b1, MAX_C};
    end else begin
      r = {1'b0, c - WIDTH'(1)};
    end
    return r;
  endfunction

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             tick_s;
  logic [WIDTH-1:0] load_clamped_s;
  logic [WIDTH:0]   stepped_s;

  // Clamp the parallel-load value into the legal count range.
  always_comb begin
    load_clamped_s = load_val;
    if ({1'b0, load_val} > MAX_X) begin
      load_clamped_s = MAX_C;
    end else begin
      load_clamped_s = load_val;
    end
  end

  // Prescaler: a tick fires on the last enabled cycle of each period; load restarts the period.
  always_comb begin
    ps_d   = ps_q;
    tick_s = 1'b0;
    if (load) begin
      ps_d = PS_ZERO;
    end else if (En) begin
      if (ps_q == PS_LAST) begin
        ps_d   = PS_ZERO;
        tick_s = 1'b1;
      end else begin
        ps_d = ps_q + PS_W'(1);
      end
    end else begin
      ps_d = ps_q;
    end
  end

  // Candidate count for a step in the currently requested direction.
  always_comb begin
    stepped_s = {1'b0, cnt_q};
    if (up_dn) begin
      stepped_s = count_up(cnt_q);
    end else begin
      stepped_s = count_down(cnt_q);
    end
  end

  // Count next-state: load beats a coincident tick, which is simply dropped.
  always_comb begin
    cnt_d  = cnt_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (load) begin
      cnt_d = load_clamped_s;
    end else if (tick_s) begin
      cnt_d  = stepped_s[WIDTH-1:0];
      step_d = 1'b1;
      wrap_d = stepped_s[WIDTH];
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= ZERO_C;
      ps_q   <= PS_ZERO;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ps_q   <= ps_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt  = cnt_q;
  assign step = step_q;
  assign wrap = wrap_q;
  assign tc   = up_dn ? (cnt_q == MAX_C) : (cnt_q == ZERO_C);

  param_updown_counter_chk #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_chk (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt_q),
    .step (step_q),
    .wrap (wrap_q)
  );

endmodule

// -----------------------------------------------------------------------------
// param_updown_counter_chk
//
// Invariants of the counter: count stays in range, a wrap is always a step,
// and one cycle after reset everything is back at zero.
//
// Ports:
//   clk, rst  in  counter clock and reset
//   cnt       in  registered count
//   step      in  registered step pulse
//   wrap      in  registered wrap pulse
// -----------------------------------------------------------------------------
module param_updown_counter_chk #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = 255
) (
  input logic             clk,
  input logic             rst,
  input logic [WIDTH-1:0] cnt,
  input logic             step,
  input logic             wrap
);

  localparam logic [WIDTH:0] MAX_X = {1'b0, MAX_VAL[WIDTH-1:0]};

  logic rst_q;

  // Remember that the previous edge was a reset edge.
  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  // Invariant checks sampled on every edge.
  always_ff @(posedge clk) begin
    if (rst_q) begin
      a_reset_vals: assert (cnt == {WIDTH{1'b0}} && !step && !wrap);
    end else begin
      a_in_range: assert ({1'b0, cnt} <= MAX_X);
      a_wrap_is_step: assert (!wrap || step);
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, load;
  logic [7:0] load_val;

  logic [7:0] cnt_a, cnt_b, cnt_c;
  logic       step_a, step_b, step_c;
  logic       tc_a, tc_b, tc_c;
  logic       wrap_a, wrap_b, wrap_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // A: full 8-bit range, no prescale
  param_updown_counter #(.WIDTH(8), .MAX_VAL(255), .PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst), .En(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .cnt(cnt_a), .step(step_a), .tc(tc_a), .wrap(wrap_a));

  // B: decade counter, prescale 4
  param_updown_counter #(.WIDTH(8), .MAX_VAL(9), .PRESCALE(4)) dut_b (
    .clk(clk), .rst(rst), .En(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .cnt(cnt_b), .step(step_b), .tc(tc_b), .wrap(wrap_b));

  // C: modulus 100, prescale 3
  param_updown_counter #(.WIDTH(8), .MAX_VAL(99), .PRESCALE(3)) dut_c (
    .clk(clk), .rst(rst), .En(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .cnt(cnt_c), .step(step_c), .tc(tc_c), .wrap(wrap_c));

  typedef struct {
    int         sel;
    logic [7:0] cnt;
    logic       step;
    logic       wrap;
    logic       tc;
    string      tag;
  } exp_t;

  typedef struct {
    int         sel;
    logic       rst;
    logic       load;
    logic       en;
    logic       up;
    logic [7:0] lval;
    logic [7:0] cnt;
    logic       step;
    logic       wrap;
    logic       tc;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[$];

  task automatic add(input int sel, input logic r, input logic ld, input logic e,
                     input logic u, input logic [7:0] lv, input logic [7:0] c,
                     input logic s, input logic w, input logic t);
    vec_t v;
    v.sel = sel; v.rst = r; v.load = ld; v.en = e; v.up = u; v.lval = lv;
    v.cnt = c; v.step = s; v.wrap = w; v.tc = t;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic r, input logic ld, input logic e,
                       input logic u, input logic [7:0] lv);
    rst = r; load = ld; en = e; up_dn = u; load_val = lv;
  endtask

  task automatic expect_out(input int sel, input logic [7:0] c, input logic s,
                            input logic w, input logic t, input string tag);
    exp_t x;
    x.sel = sel; x.cnt = c; x.step = s; x.wrap = w; x.tc = t; x.tag = tag;
    exp_q.push_back(x);
  endtask

  // Advance one edge, then pop and compare every pending expectation.
  task automatic clock_and_check();
    exp_t       x;
    logic [7:0] ac;
    logic       as_, aw, at;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      case (x.sel)
        0:       begin ac = cnt_a; as_ = step_a; aw = wrap_a; at = tc_a; end
        1:       begin ac = cnt_b; as_ = step_b; aw = wrap_b; at = tc_b; end
        default: begin ac = cnt_c; as_ = step_c; aw = wrap_c; at = tc_c; end
      endcase
      checks++;
      if (ac !== x.cnt || as_ !== x.step || aw !== x.wrap || at !== x.tc) begin
        errors++;
        $display("FAIL %s dut%0d t=%0t: got cnt=%0d step=%b wrap=%b tc=%b, expected cnt=%0d step=%b wrap=%b tc=%b",
                 x.tag, x.sel, $time, ac, as_, aw, at, x.cnt, x.step, x.wrap, x.tc);
      end
    end
  endtask

  task automatic run_rows(input int first, input int last, input string tag);
    for (int i = first; i <= last; i++) begin
      drive(tbl[i].rst, tbl[i].load, tbl[i].en, tbl[i].up, tbl[i].lval);
      expect_out(tbl[i].sel, tbl[i].cnt, tbl[i].step, tbl[i].wrap, tbl[i].tc,
                 $sformatf("%s_row%0d", tag, i));
      clock_and_check();
    end
  endtask

  initial begin
    int c;
    // Down count on B (MAX 9, prescale 4), starting from cnt=1, prescaler=0.
    //  sel r ld en up lval | cnt st wr tc
    add(1, 0, 1, 1, 0, 8'd2,  8'd2, 0, 0, 0);
    add(1, 0, 0, 1, 0, 8'd0,  8'd2, 0, 0, 0);
    add(1, 0, 0, 1, 0, 8'd0,  8'd2, 0, 0, 0);
    add(1, 0, 0, 1, 0, 8'd0,  8'd2, 0, 0, 0);
    add(1, 0, 0, 1, 0, 8'd0,  8'd1, 1, 0, 0);
    add(1, 0, 0, 1, 0, 8'd0,  8'd1, 0, 0, 0);
    add(1, 0, 0, 1, 0, 8'd0,  8'd1, 0, 0, 0);
    add(1, 0, 0, 1, 0, 8'd0,  8'd1, 0, 0, 0);
    add(1, 0, 0, 1, 0, 8'd0,  8'd0, 1, 0, 1);
    add(1, 0, 0, 1, 0, 8'd0,  8'd0, 0, 0, 1);
    add(1, 0, 0, 1, 0, 8'd0,  8'd0, 0, 0, 1);
    add(1, 0, 0, 1, 0, 8'd0,  8'd0, 0, 0, 1);
    add(1, 0, 0, 1, 0, 8'd0,  8'd9, 1, 1, 0);
    add(1, 0, 0, 1, 0, 8'd0,  8'd9, 0, 0, 0);
    add(1, 0, 0, 1, 0, 8'd0,  8'd9, 0, 0, 0);
    add(1, 0, 0, 1, 0, 8'd0,  8'd9, 0, 0, 0);
    add(1, 0, 0, 1, 0, 8'd0,  8'd8, 1, 0, 0);
    add(1, 0, 0, 1, 0, 8'd0,  8'd8, 0, 0, 0);
    add(1, 0, 0, 1, 0, 8'd0,  8'd8, 0, 0, 0);   // prescaler now 2
    // Clamp, load-vs-tick and load-while-disabled on C (MAX 99, prescale 3).
    add(2, 1, 0, 0, 1, 8'd0,   8'd0,  0, 0, 0);
    add(2, 0, 1, 1, 1, 8'd200, 8'd99, 0, 0, 1);
    add(2, 0, 0, 1, 1, 8'd0,   8'd99, 0, 0, 1);
    add(2, 0, 0, 1, 1, 8'd0,   8'd99, 0, 0, 1);
    add(2, 0, 1, 1, 1, 8'd50,  8'd50, 0, 0, 0);  // load on the tick cycle
    add(2, 0, 0, 1, 1, 8'd0,   8'd50, 0, 0, 0);
    add(2, 0, 0, 1, 1, 8'd0,   8'd50, 0, 0, 0);
    add(2, 0, 0, 1, 1, 8'd0,   8'd51, 1, 0, 0);
    add(2, 0, 1, 0, 1, 8'd100, 8'd99, 0, 0, 1);
    add(2, 0, 0, 1, 1, 8'd0,   8'd99, 0, 0, 1);
    add(2, 0, 0, 1, 1, 8'd0,   8'd99, 0, 0, 1);
    add(2, 0, 0, 1, 1, 8'd0,   8'd0,  1, 1, 0);
    add(2, 0, 1, 0, 1, 8'd99,  8'd99, 0, 0, 1);
    add(2, 0, 0, 0, 0, 8'd0,   8'd99, 0, 0, 0);
    add(2, 0, 1, 1, 0, 8'd0,   8'd0,  0, 0, 1);
    add(2, 0, 0, 0, 0, 8'd0,   8'd0,  0, 0, 1);

    // Reset state with both directions
    drive(1, 0, 0, 1, 8'd0);
    for (int s = 0; s < 3; s++) expect_out(s, 8'd0, 0, 0, 0, "reset_up");
    clock_and_check();
    drive(1, 0, 0, 0, 8'd0);
    for (int s = 0; s < 3; s++) expect_out(s, 8'd0, 0, 0, 1, "reset_dn");
    clock_and_check();

    // Free-running full-range up count
    drive(0, 0, 1, 1, 8'd0);
    for (int k = 1; k <= 260; k++) begin
      expect_out(0, 8'(k % 256), 1'b1, (k == 256), ((k % 256) == 255), "t1_run");
      clock_and_check();
    end

    // Prescaled decade up count
    drive(1, 0, 1, 1, 8'd0);
    expect_out(1, 8'd0, 0, 0, 0, "t2_rst");
    clock_and_check();
    drive(0, 0, 1, 1, 8'd0);
    for (int k = 1; k <= 44; k++) begin
      c = (k / 4) % 10;
      expect_out(1, 8'(c), ((k % 4) == 0), ((k % 4) == 0) && (c == 0), (c == 9), "t2_run");
      clock_and_check();
    end

    run_rows(0, 18, "t3_down");

    // Enable low mid-prescale: everything freezes, then two more cycles to the step
    drive(0, 0, 0, 0, 8'd0);
    for (int k = 0; k < 10; k++) begin
      expect_out(1, 8'd8, 0, 0, 0, "t5_hold");
      clock_and_check();
    end
    drive(0, 0, 1, 0, 8'd0);
    expect_out(1, 8'd8, 0, 0, 0, "t5_resume1");
    clock_and_check();
    expect_out(1, 8'd7, 1, 0, 0, "t5_resume2");
    clock_and_check();

    // Reset beats load while at cnt=7; counting restarts from zero
    drive(1, 1, 1, 0, 8'd5);
    expect_out(1, 8'd0, 0, 0, 1, "t6_rst");
    clock_and_check();
    drive(0, 0, 1, 0, 8'd0);
    for (int k = 1; k <= 3; k++) begin
      expect_out(1, 8'd0, 0, 0, 1, "t6_wait");
      clock_and_check();
    end
    expect_out(1, 8'd9, 1, 1, 0, "t6_step");
    clock_and_check();

    run_rows(19, tbl.size() - 1, "t4_load");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
